vga_scanout: RTL and testbench

//   Consumer-side VGA timing and scan-out engine for the Pong display path.

---
 rtl/vga_scanout.sv | 91 +++++++++
 tb/tb_vga_scanout.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout - VGA raster timing and scan-out for the Pong display path.
//
// Runs the horizontal/vertical pixel counters, presents 1-based raster
// coordinates to img_generator, takes its color back one clock later and
// drives blanking-masked RGB plus hsync/vsync to the DAC. Also pulses a
// once-per-frame tick for frame-locked game logic.
//
// Ports:
//   CLOCK_25    in   pixel clock, one pixel per rising edge
//   RESET_N     in   asynchronous active-low reset
//   x, y        out  12-bit 1-based raster coordinates (registered)
//   color       in   3-bit pixel color for the current (x, y)
//   rgb         out  {R,G,B}, forced to 0 during blanking
//   hsync       out  horizontal sync, asserted level = SYNC_POL
//   vsync       out  vertical sync, asserted level = SYNC_POL
//   frame_tick  out  one-cycle pulse coincident with rgb of pixel (1,1)
module vga_scanout #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    output logic [11:0] x,
    output logic [11:0] y,
    input  logic [2:0]  color,
    output logic [2:0]  rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam logic [11:0] H_TOT   = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [11:0] V_TOT   = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [11:0] H_VIS   = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS   = 12'(V_VISIBLE);
    localparam logic [11:0] HS_BEG  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END  = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END  = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [11:0] h_cnt, v_cnt;
    logic [11:0] h_nxt, v_nxt;
    logic        visible, hs_act, vs_act;

    always_comb begin
        h_nxt = h_cnt + 12'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_TOT - 12'd1) begin
            h_nxt = 12'd0;
            v_nxt = (v_cnt == V_TOT - 12'd1) ? 12'd0 : v_cnt + 12'd1;
        end
    end

    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_act  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_act  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // x/y are kept as their own registers (loaded with next count + 1) so
    // img_generator sees clean flop outputs rather than an adder.
    // The blanking mux uses a known select, so an X on color outside the
    // visible window never reaches rgb.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt      <= 12'd0;
            v_cnt      <= 12'd0;
            x          <= 12'd1;
            y          <= 12'd1;
            rgb        <= 3'b000;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            frame_tick <= 1'b0;
        end else begin
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            x          <= h_nxt + 12'd1;
            y          <= v_nxt + 12'd1;
            rgb        <= visible ? color : 3'b000;
            hsync      <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync      <= vs_act ? SYNC_POL : ~SYNC_POL;
            frame_tick <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout - directed bench for vga_scanout.
// dut_d runs the 640x480 defaults (line-level timing); dut_s runs a tiny
// 8x6 raster so whole frames and mid-frame reset fit in a short run.
module tb_vga_scanout;

    logic        clk;
    logic        rst_d, rst_s;
    logic [2:0]  col_d, col_s;
    logic [11:0] x_d, y_d, x_s, y_s;
    logic [2:0]  rgb_d, rgb_s;
    logic        hs_d, vs_d, ft_d, hs_s, vs_s, ft_s;

    vga_scanout dut_d (
        .CLOCK_25(clk), .RESET_N(rst_d), .x(x_d), .y(y_d), .color(col_d),
        .rgb(rgb_d), .hsync(hs_d), .vsync(vs_d), .frame_tick(ft_d)
    );

    vga_scanout #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_s (
        .CLOCK_25(clk), .RESET_N(rst_s), .x(x_s), .y(y_s), .color(col_s),
        .rgb(rgb_s), .hsync(hs_s), .vsync(vs_s), .frame_tick(ft_s)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        logic [11:0] x, y;
        logic [2:0]  rgb;
        logic        hs, vs, ft;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   sel;      // 0: dut_d, 1: dut_s
    int   t;        // cycles since reset release for the selected instance

    // run-length / period trackers on observed outputs
    int hs_run, vs_run, on_run, off_run, line_cnt, ft_cnt, hits;
    bit line_seen, ft_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_trk();
        hs_run = 0; vs_run = 0; on_run = 0; off_run = 0;
        line_cnt = 0; ft_cnt = 0; hits = 0;
        line_seen = 0; ft_seen = 0;
    endtask

    // One pixel clock: drive color for model state t, push the expected
    // outputs of that state, clock, then pop and compare on the falling edge.
    task automatic step();
        int hv, hf, hsw, ht, vv, vf, vsw, vt, h, v, hn, vn;
        bit vis;
        logic [2:0] c;
        exp_t e, g;
        if (!sel) begin hv = 640; hf = 16; hsw = 96; ht = 800; vv = 480; vf = 10; vsw = 2; vt = 525; end
        else      begin hv = 4;   hf = 1;  hsw = 2;  ht = 8;   vv = 3;   vf = 1;  vsw = 1; vt = 6;   end
        h   = t % ht;
        v   = (t / ht) % vt;
        hn  = (t + 1) % ht;
        vn  = ((t + 1) / ht) % vt;
        vis = (h < hv) && (v < vv);
        if (!sel) begin
            c = vis ? 3'b101 : 3'bxxx;
            col_d = c;
        end else begin
            c = (h == hv - 1 && v == vv - 1) ? 3'b111 : 3'b000;
            col_s = c;
        end
        e.x   = 12'(hn + 1);
        e.y   = 12'(vn + 1);
        e.rgb = vis ? c : 3'b000;
        e.hs  = (h >= hv + hf && h < hv + hf + hsw) ? 1'b0 : 1'b1;
        e.vs  = (v >= vv + vf && v < vv + vf + vsw) ? 1'b0 : 1'b1;
        e.ft  = (h == 0 && v == 0);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        g = q.pop_front();
        if (!sel) begin
            chk("x", x_d, g.x);   chk("y", y_d, g.y);   chk("rgb", rgb_d, g.rgb);
            chk("hsync", hs_d, g.hs); chk("vsync", vs_d, g.vs); chk("frame_tick", ft_d, g.ft);
            // per-line run lengths on the default raster
            if (hs_d == 1'b0) hs_run++;
            else if (hs_run != 0) begin chk("hsync_low_len", hs_run, 96); hs_run = 0; end
            if (rgb_d === 3'b101) begin
                if (off_run != 0) begin chk("blank_len", off_run, 160); off_run = 0; end
                on_run++;
            end else begin
                if (on_run != 0) begin chk("active_len", on_run, 640); on_run = 0; end
                off_run++;
            end
            line_cnt++;
            if (x_d == 12'd1) begin
                if (line_seen) chk("line_period", line_cnt, 800);
                line_seen = 1; line_cnt = 0;
            end
        end else begin
            chk("x_s", x_s, g.x);   chk("y_s", y_s, g.y);   chk("rgb_s", rgb_s, g.rgb);
            chk("hsync_s", hs_s, g.hs); chk("vsync_s", vs_s, g.vs); chk("frame_tick_s", ft_s, g.ft);
            if (vs_s == 1'b0) vs_run++;
            else if (vs_run != 0) begin chk("vsync_low_len_s", vs_run, 8); vs_run = 0; end
            if (rgb_s === 3'b111) hits++;
            line_cnt++;
            if (x_s == 12'd1) begin
                if (line_seen) chk("line_period_s", line_cnt, 8);
                line_seen = 1; line_cnt = 0;
            end
            ft_cnt++;
            if (ft_s) begin
                if (ft_seen) begin
                    chk("frame_period_s", ft_cnt, 48);
                    chk("corner_hits_s", hits, 1);
                end
                ft_seen = 1; ft_cnt = 0; hits = 0;
            end
        end
        t++;
    endtask

    task automatic chk_reset_d(input string tag);
        chk({tag, "_x"}, x_d, 12'd1);   chk({tag, "_y"}, y_d, 12'd1);
        chk({tag, "_rgb"}, rgb_d, 3'b000);
        chk({tag, "_hs"}, hs_d, 1'b1);  chk({tag, "_vs"}, vs_d, 1'b1);
        chk({tag, "_ft"}, ft_d, 1'b0);
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, "_x"}, x_s, 12'd1);   chk({tag, "_y"}, y_s, 12'd1);
        chk({tag, "_rgb"}, rgb_s, 3'b000);
        chk({tag, "_hs"}, hs_s, 1'b1);  chk({tag, "_vs"}, vs_s, 1'b1);
        chk({tag, "_ft"}, ft_s, 1'b0);
    endtask

    initial begin
        rst_d = 1'b0; rst_s = 1'b0;
        col_d = 3'b000; col_s = 3'b000;
        sel = 0; t = 0;
        clear_trk();

        // reset held for 5 clocks, both instances
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_reset_d("rst_d");
            chk_reset_s("rst_s");
        end

        // default raster: two full lines plus a little
        rst_d = 1'b1;
        sel = 0; t = 0; clear_trk();
        for (int i = 0; i < 1700; i++) step();
        chk("lines_seen", line_seen, 1'b1);

        // small raster: > two full frames
        rst_d = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        sel = 1; t = 0; clear_trk();
        for (int i = 0; i < 110; i++) step();
        chk("frames_seen_s", ft_seen, 1'b1);

        // mid-frame reset during vsync (state h=2, v=4 shows x=4, y=5, vsync low)
        t = 0; rst_s = 1'b0; @(negedge clk); rst_s = 1'b1; clear_trk();
        for (int i = 0; i < 35; i++) step();
        chk("pre_rst_vs_s", vs_s, 1'b0);
        #2 rst_s = 1'b0;
        #1 chk_reset_s("async_rst_s");
        @(negedge clk);
        chk_reset_s("held_rst_s");

        // recovery after release
        rst_s = 1'b1;
        t = 0; clear_trk();
        for (int i = 0; i < 60; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
